// File: rtl/ram_2r2w.sv
// ============================================================================
// Module   : ram_2r2w
// Brief    : 2048x32 two-read / two-write RAM using a Live Value Table.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_2r2w #(
    parameter int BLOCKSIZE = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BLOCKSIZE:0]   w_addr_1,
    input  logic [31:0]          w_din_1,
    input  logic                 w_enb_1,
    input  logic [BLOCKSIZE:0]   w_addr_2,
    input  logic [31:0]          w_din_2,
    input  logic                 w_enb_2,
    input  logic [BLOCKSIZE:0]   r_addr_1,
    output logic [31:0]          r_dout_1,
    input  logic [BLOCKSIZE:0]   r_addr_2,
    output logic [31:0]          r_dout_2
);

    localparam int C_DEPTH = 1 << (BLOCKSIZE + 1);

    // bank_<w><r>_q : written by write port w, read by read port r
    logic [31:0]        bank_11_q [C_DEPTH];
    logic [31:0]        bank_12_q [C_DEPTH];
    logic [31:0]        bank_21_q [C_DEPTH];
    logic [31:0]        bank_22_q [C_DEPTH];
    logic [C_DEPTH-1:0] lvt_q;
    logic [31:0]        dout_1_q;
    logic [31:0]        dout_2_q;
    logic [31:0]        dout_1_d;
    logic [31:0]        dout_2_d;

    // Bank contents survive reset; only the LVT and read registers clear.
    always_ff @(posedge clk) begin
        if (!rst && w_enb_1) begin
            bank_11_q[w_addr_1] <= w_din_1;
            bank_12_q[w_addr_1] <= w_din_1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_enb_2) begin
            bank_21_q[w_addr_2] <= w_din_2;
            bank_22_q[w_addr_2] <= w_din_2;
        end
    end

    // Port 2 assignment comes last so it wins an address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            lvt_q <= '0;
        end else begin
            if (w_enb_1) begin
                lvt_q[w_addr_1] <= 1'b0;
            end
            if (w_enb_2) begin
                lvt_q[w_addr_2] <= 1'b1;
            end
        end
    end

    always_comb begin
        dout_1_d = lvt_q[r_addr_1] ? bank_21_q[r_addr_1] : bank_11_q[r_addr_1];
        dout_2_d = lvt_q[r_addr_2] ? bank_22_q[r_addr_2] : bank_12_q[r_addr_2];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_1_q <= '0;
            dout_2_q <= '0;
        end else begin
            dout_1_q <= dout_1_d;
            dout_2_q <= dout_2_d;
        end
    end

    assign r_dout_1 = dout_1_q;
    assign r_dout_2 = dout_2_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_2r2w.sv
// ============================================================================
// Module   : tb_ram_2r2w
// Brief    : Self-checking bench for ram_2r2w: directed vectors plus a
//            per-port shadow-memory model checked every cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_2r2w;

    localparam int C_DEPTH = 2048;

    logic        clk;
    logic        rst;
    logic [10:0] w_addr_1, w_addr_2, r_addr_1, r_addr_2;
    logic [31:0] w_din_1, w_din_2;
    logic        w_enb_1, w_enb_2;
    logic [31:0] r_dout_1, r_dout_2;

    int checks;
    int errors;

    ram_2r2w #(.BLOCKSIZE(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .w_addr_1 (w_addr_1),
        .w_din_1  (w_din_1),
        .w_enb_1  (w_enb_1),
        .w_addr_2 (w_addr_2),
        .w_din_2  (w_din_2),
        .w_enb_2  (w_enb_2),
        .r_addr_1 (r_addr_1),
        .r_dout_1 (r_dout_1),
        .r_addr_2 (r_addr_2),
        .r_dout_2 (r_dout_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: last value each write port stored per address, and which port
    // wrote most recently (cleared by reset, so port 1's value becomes live).
    logic [31:0] m_val  [2][C_DEPTH];
    bit          m_ok   [2][C_DEPTH];
    bit          m_last2[C_DEPTH];
    logic [31:0] exp_1, exp_2;
    bit          vld_1, vld_2;

    initial begin
        for (int i = 0; i < C_DEPTH; i++) begin
            m_ok[0][i] = 0; m_ok[1][i] = 0; m_last2[i] = 0;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            exp_1 = '0; exp_2 = '0; vld_1 = 1; vld_2 = 1;
            for (int i = 0; i < C_DEPTH; i++) m_last2[i] = 0;
        end else begin
            vld_1 = m_ok[m_last2[r_addr_1]][r_addr_1];
            exp_1 = m_val[m_last2[r_addr_1]][r_addr_1];
            vld_2 = m_ok[m_last2[r_addr_2]][r_addr_2];
            exp_2 = m_val[m_last2[r_addr_2]][r_addr_2];
            if (w_enb_1) begin
                m_val[0][w_addr_1] = w_din_1; m_ok[0][w_addr_1] = 1; m_last2[w_addr_1] = 0;
            end
            if (w_enb_2) begin
                m_val[1][w_addr_2] = w_din_2; m_ok[1][w_addr_2] = 1; m_last2[w_addr_2] = 1;
            end
        end
        #1;
        if (vld_1) begin
            checks++;
            if (r_dout_1 !== exp_1) begin
                errors++;
                $display("FAIL model_dout_1 t=%0t actual=%h expected=%h", $time, r_dout_1, exp_1);
            end
        end
        if (vld_2) begin
            checks++;
            if (r_dout_2 !== exp_2) begin
                errors++;
                $display("FAIL model_dout_2 t=%0t actual=%h expected=%h", $time, r_dout_2, exp_2);
            end
        end
    end

    task automatic step(input bit we1, input int a1, input logic [31:0] d1,
                        input bit we2, input int a2, input logic [31:0] d2,
                        input int ra1, input int ra2);
        @(negedge clk);
        w_enb_1 = we1; w_addr_1 = 11'(a1); w_din_1 = d1;
        w_enb_2 = we2; w_addr_2 = 11'(a2); w_din_2 = d2;
        r_addr_1 = 11'(ra1); r_addr_2 = 11'(ra2);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Waits for the edge that samples the last step's inputs, then checks.
    task automatic expect_rd(input string name, input logic [31:0] e1, input logic [31:0] e2);
        @(posedge clk);
        #2;
        chk({name, "_p1"}, r_dout_1, e1);
        chk({name, "_p2"}, r_dout_2, e2);
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1;
        w_enb_1 = 0; w_enb_2 = 0; w_addr_1 = 0; w_addr_2 = 0;
        w_din_1 = 0; w_din_2 = 0; r_addr_1 = 0; r_addr_2 = 0;
        @(posedge clk); #2;
        chk("reset_p1", r_dout_1, 32'h0);
        chk("reset_p2", r_dout_2, 32'h0);
        @(posedge clk);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        // Per-port write/read, including swapped read ports
        step(1, 5, 32'hDEADBEEF, 1, 2047, 32'h12345678, 0, 0);
        step(0, 0, 0, 0, 0, 0, 5, 2047);
        expect_rd("basic", 32'hDEADBEEF, 32'h12345678);
        step(0, 0, 0, 0, 0, 0, 2047, 5);
        expect_rd("swapped", 32'h12345678, 32'hDEADBEEF);

        // Disabled writes with toggling address/data change nothing
        step(0, 5, 32'hFFFFFFFF, 0, 2047, 32'h0, 0, 0);
        step(0, 2047, 32'h0, 0, 5, 32'hFFFFFFFF, 0, 0);
        step(0, 0, 0, 0, 0, 0, 5, 2047);
        expect_rd("disabled", 32'hDEADBEEF, 32'h12345678);

        // LVT switching on address 0
        step(1, 0, 32'h11111111, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        expect_rd("lvt_a", 32'h11111111, 32'h11111111);
        step(0, 0, 0, 1, 0, 32'h22222222, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        expect_rd("lvt_b", 32'h22222222, 32'h22222222);
        step(1, 0, 32'h33333333, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        expect_rd("lvt_c", 32'h33333333, 32'h33333333);

        // Write-write collision: port 2 wins
        step(1, 100, 32'hAAAA0001, 1, 100, 32'hBBBB0002, 0, 0);
        step(0, 0, 0, 0, 0, 0, 100, 100);
        expect_rd("collision", 32'hBBBB0002, 32'hBBBB0002);

        // Read-during-write returns the old value
        step(1, 7, 32'h5, 0, 0, 0, 0, 0);
        step(1, 7, 32'h9, 0, 0, 0, 7, 7);
        expect_rd("rdw_old", 32'h5, 32'h5);
        step(0, 0, 0, 0, 0, 0, 7, 7);
        expect_rd("rdw_new", 32'h9, 32'h9);

        // Fill every address: port 1 on even, port 2 on odd
        for (int i = 0; i < C_DEPTH / 2; i++)
            step(1, 2 * i, 32'hA000_0000 | 32'(2 * i), 1, 2 * i + 1, 32'hB000_0000 | 32'(2 * i + 1), i, C_DEPTH - 1 - i);
        step(0, 0, 0, 0, 0, 0, 1, 1);
        expect_rd("fill_odd", 32'hB000_0001, 32'hB000_0001);

        // Random 2W+2R traffic with forced collisions and read-during-write
        for (int i = 0; i < 600; i++) begin
            int a1, a2, ra1, ra2;
            a1  = $urandom_range(0, C_DEPTH - 1);
            a2  = ($urandom_range(0, 7) == 0) ? a1 : $urandom_range(0, C_DEPTH - 1);
            ra1 = ($urandom_range(0, 3) == 0) ? a1 : $urandom_range(0, C_DEPTH - 1);
            ra2 = ($urandom_range(0, 3) == 0) ? a2 : $urandom_range(0, C_DEPTH - 1);
            step(bit'($urandom_range(0, 1)), a1, $urandom, bit'($urandom_range(0, 1)), a2, $urandom, ra1, ra2);
        end

        // Mid-stream reset: write dropped, outputs zero, LVT back to port 1
        step(1, 200, 32'h00C0FFEE, 1, 201, 32'h0BADF00D, 200, 201);
        step(1, 50, 32'h1234ABCD, 1, 51, 32'h5555AAAA, 50, 51);
        rst = 1'b1;
        expect_rd("mid_reset", 32'h0, 32'h0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        step(0, 0, 0, 0, 0, 0, 200, 0);
        @(posedge clk); #2;
        chk("post_reset_p1", r_dout_1, 32'h00C0FFEE);
        for (int i = 0; i < 200; i++)
            step(0, 0, 0, 0, 0, 0, $urandom_range(0, C_DEPTH - 1), $urandom_range(0, C_DEPTH - 1));

        step(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #3;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ram_2r2w.md
# ram_2r2w

Two-read / two-write (2R2W) 32-bit RAM built with the Live Value Table (LVT) method. It provides 2048 words, two independent write ports and two independent read ports, all usable in the same cycle. Each write port owns a bank of replicated storage, one copy per read port. A 1-bit-per-word LVT records which write port last wrote each address and steers each read port to the bank holding the live value. The block serves as a multi-ported register/storage array for cores that need two reads and two writes per cycle.

## Interface
- BLOCKSIZE, 10: address MSB index; address width = BLOCKSIZE+1 (11 bits); depth = 2^(BLOCKSIZE+1) = 2048 words.
- Data width: fixed at 32.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- w_addr_1  in  BLOCKSIZE+1  write port 1 address.
- w_din_1  in  32  write port 1 data.
- w_enb_1  in  1  write port 1 enable, active-high.
- w_addr_2  in  BLOCKSIZE+1  write port 2 address.
- w_din_2  in  32  write port 2 data.
- w_enb_2  in  1  write port 2 enable, active-high.
- r_addr_1  in  BLOCKSIZE+1  read port 1 address.
- r_dout_1  out  32  read port 1 data, registered.
- r_addr_2  in  BLOCKSIZE+1  read port 2 address.
- r_dout_2  out  32  read port 2 data, registered.

## Operation
- Storage is four banks B[w][r], each 2048x32, with w, r ∈ {1,2}:
  - Write port w writes both B[w][1] and B[w][2] at the same address.
  - Read port r reads only B[1][r] and B[2][r].
- The LVT is 2048x1 flops; value 0 selects write port 1, value 1 selects write port 2.
- Write, per port w with w_enb_w=1 and rst=0:
  - B[w][*][w_addr_w] <= w_din_w.
  - LVT[w_addr_w] <= (w==2).
- Read, per port r with rst=0: r_dout_r <= B[LVT[r_addr_r]+1][r][r_addr_r]. All values used are the ones present before the edge.
- Write-write collision (w_addr_1 == w_addr_2, both enabled): port 2 wins.
  - The LVT is set to 1.
  - Port 1's bank still holds its data, but that data is dead.
- Read-during-write to the same address in the same cycle returns the old value (read-before-write). The new value is visible to reads issued on the next cycle.
- Both read ports may read the same or different addresses freely, with no interaction.
- Reset (rst=1 at an edge):
  - LVT cleared to all 0.
  - r_dout_1 and r_dout_2 cleared to 0.
  - Writes are ignored that cycle.
  - Bank contents are not cleared.
  - After reset, a location not yet written reads an unspecified value.
- Disabled write ports have no effect regardless of address/data values.

## Timing
- Read latency is 1 cycle: the address sampled at edge N produces data on r_dout at edge N (held until edge N+1).
- Write-to-read latency:
  - A write at edge N is returned by a read whose address is sampled at edge N+1 or later.
  - A read sampled at edge N returns the pre-write value.
- Throughput: 2 writes + 2 reads every cycle, no stalls, no handshake.
- r_dout holds its last value only while reads continue. A new read result appears every cycle; there is no read enable.
- Reset asserted mid-stream:
  - Outputs read 0 on the cycle after the reset edge.
  - Pending same-edge writes are dropped.
  - Resumed reads return bank data selected by the cleared LVT (port 1 banks).

## Test plan
- Reset: rst=1 for 2 cycles -> r_dout_1 = r_dout_2 = 0 after the first reset edge.
- Per-port write/read: port 1 writes 0xDEADBEEF @5, port 2 writes 0x12345678 @2047; next cycle r_addr_1=5, r_addr_2=2047 -> r_dout_1=0xDEADBEEF, r_dout_2=0x12345678 one cycle later. Also read swapped addresses on opposite ports.
- LVT switching: port 1 writes 0x11111111 @0, then port 2 writes 0x22222222 @0, then port 1 writes 0x33333333 @0. Reading @0 on both ports after each write -> 0x11111111, 0x22222222, 0x33333333.
- Write collision: both ports write @100 in the same cycle (0xAAAA0001 port 1, 0xBBBB0002 port 2) -> both read ports later return 0xBBBB0002.
- Read-during-write: @7 holds 0x5; in one cycle port 1 writes 0x9 @7 while r_addr_1=7 -> r_dout_1=0x5; next read -> 0x9.
- Enables and throughput: w_enb low with address/data toggling -> contents unchanged. Random back-to-back 2W+2R traffic over all 2048 addresses checked against a scoreboard that models port-2-wins and read-before-write.
